unified_memory_arbiter: RTL and testbench
=========================================

UNIFIED_MEMORY_ARBITER -- requirements
Module: unified_memory_arbiter

Interface
REQ-001 The block SHALL have parameter CORE, default 0, core index (informational only).
REQ-002 The block SHALL have parameter ADDRESS_BITS, default 20, address width of all request ports.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 32, data width of all data ports.
REQ-004 The block SHALL have port clock, input, 1, the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port i_req_valid, input, 1, instruction-fetch read request.
REQ-007 The block SHALL have port i_req_ready, output, 1, instruction request accepted this cycle.
REQ-008 The block SHALL have port i_req_address, input, ADDRESS_BITS, fetch address.
REQ-009 The block SHALL have port d_req_valid, input, 1, data request.
REQ-010 The block SHALL have port d_req_ready, output, 1, data request accepted this cycle.
REQ-011 The block SHALL have port d_req_write, input, 1, data store (1) or load (0).
REQ-012 The block SHALL have port d_req_address, input, ADDRESS_BITS, load/store address.
REQ-013 The block SHALL have port d_req_data, input, DATA_WIDTH, store data.
REQ-014 The block SHALL have port i_resp_valid, output, 1, one-cycle pulse: fetch data on resp_data.
REQ-015 The block SHALL have port d_resp_valid, output, 1, one-cycle pulse: load data on resp_data.
REQ-016 The block SHALL have port resp_data, output, DATA_WIDTH, registered read data.
REQ-017 The block SHALL have port mem_req_valid, output, 1, request to the shared memory.
REQ-018 The block SHALL have port mem_req_ready, input, 1, shared memory accepts the request.
REQ-019 The block SHALL have port mem_req_write, output, 1, shared memory write enable.
REQ-020 The block SHALL have port mem_req_address, output, ADDRESS_BITS, shared memory address.
REQ-021 The block SHALL have port mem_req_data, output, DATA_WIDTH, shared memory write data.
REQ-022 The block SHALL have port mem_resp_valid, input, 1, shared memory read data valid.
REQ-023 The block SHALL have port mem_resp_data, input, DATA_WIDTH, shared memory read data.

Function
REQ-024 The FSM SHALL have states IDLE, ISSUE and WAIT, with at most one transaction outstanding.
REQ-025 In IDLE, i_req_ready/d_req_ready SHALL be asserted combinationally, only to the granted requester, only if its valid is high.
REQ-026 On acceptance, address, data, write and owner SHALL be latched and the FSM SHALL go to ISSUE; instruction requests always latch write=0.
REQ-027 In ISSUE, mem_req_valid SHALL be 1 and mem_req_* SHALL hold the latched values stable until the cycle in which mem_req_ready=1.
REQ-028 On the ISSUE handshake, a write SHALL return the FSM to IDLE with no response pulse, and a read SHALL go to WAIT.
REQ-029 In WAIT, on mem_resp_valid=1, resp_data SHALL register mem_resp_data, the owner's resp_valid SHALL pulse for exactly the next cycle, and the FSM SHALL go to IDLE.
REQ-030 Latency: accept at cycle N; mem_req_valid at N+1; with mem_req_ready at N+1 and mem_resp_valid at N+2, resp_valid SHALL be at N+3 and the next acceptance SHALL be possible at N+3.
REQ-031 mem_resp_valid outside WAIT SHALL be ignored, and mem_req_ready outside ISSUE SHALL be ignored.
REQ-032 A requester deasserting valid before it is granted SHALL have no effect; no ready SHALL be given outside IDLE.
REQ-033 Tie-break SHALL follow REQ-037; a single valid requester SHALL always be granted.

Reset
REQ-034 While reset=1, the FSM SHALL go to IDLE; all ready/valid outputs, resp_data, mem_req_write, mem_req_address and mem_req_data SHALL be 0; last_grant SHALL become instruction.
REQ-035 Reset mid-transaction SHALL discard the in-flight request, and no response SHALL be produced for it.

Configuration
REQ-036 The macro ARBITER_ROUND_ROBIN_EN SHALL select the arbitration mode.
REQ-037 When ARBITER_ROUND_ROBIN_EN is defined, a tie SHALL grant the port not in last_grant, and last_grant SHALL update on every acceptance; when it is undefined, a tie SHALL always grant the data port and last_grant SHALL be absent.

Structure
REQ-038 The state encodings and owner encodings (OWNER_I=0, OWNER_D=1) SHALL reside in shared package memory_arbiter_pkg.
REQ-039 The grant computation SHALL be sub-module arbiter_grant_select (inputs: two valids and last_grant; output: grant).

Verification
REQ-040 i_req_valid=1 at address 0x00010 and memory responding with 0xDEADBEEF one cycle after acceptance -> i_resp_valid pulses once and resp_data=0xDEADBEEF, with no d_resp_valid.
REQ-041 Store to address 0x00100 with data 0x12345678 and mem_req_ready held 0 for 3 cycles -> mem_req_* stays stable for 4 cycles, then the FSM returns to IDLE with no response pulse.
REQ-042 Both valid continuously for 4 transactions -> round-robin builds grant D, I, D, I; fixed-priority builds grant D, D, D, D.
REQ-043 Reset asserted during WAIT, then a late mem_resp_valid -> no resp_valid pulse, and the FSM is in IDLE.
REQ-044 A spurious mem_resp_valid in IDLE -> no response pulse, and resp_data is unchanged.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// memory_arbiter_pkg
//
// Purpose : Shared definitions for the unified memory arbiter. This holds the
//           arbiter FSM state encoding and the requester (owner) encoding that
//           both the top level and the grant selector use.
//
// Contents: state_t - IDLE / ISSUE / WAIT transaction phases
//           owner_t - OWNER_I (instruction fetch) = 0, OWNER_D (data) = 1
// ----------------------------------------------------------------------------
package memory_arbiter_pkg;

    // Phases of the single outstanding memory transaction
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Which requester owns the current transaction (and who won the last tie)
    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

endpackage : memory_arbiter_pkg

// File: rtl/arbiter_grant_select.sv
// ----------------------------------------------------------------------------
// arbiter_grant_select
//
// Purpose : Decides which requester is granted when the arbiter is idle.
//           A single valid requester always wins. On a tie the result depends
//           on the build:
//             ARBITER_ROUND_ROBIN_EN defined   -> grant the port that did not
//                                                 win last time (last_grant_i)
//             ARBITER_ROUND_ROBIN_EN undefined -> the data port always wins and
//                                                 last_grant_i is not looked at
//
// Ports   : i_valid_i    - instruction requester valid
//           d_valid_i    - data requester valid
//           last_grant_i - owner granted on the previous acceptance
//           grant_o      - selected owner (meaningful only if a valid is high)
// ----------------------------------------------------------------------------
module arbiter_grant_select
    import memory_arbiter_pkg::*;
(
    input  logic   i_valid_i,
    input  logic   d_valid_i,
    input  owner_t last_grant_i,
    output owner_t grant_o
);

`ifndef ARBITER_ROUND_ROBIN_EN
    // Fixed-priority builds carry the port only to keep one interface
    owner_t unusedLastGrant;
    assign unusedLastGrant = last_grant_i;
`endif

    // Pick the winner: lone requester first, then the tie-break policy
    always_comb begin
        grant_o = OWNER_I;
        if (i_valid_i && d_valid_i) begin
`ifdef ARBITER_ROUND_ROBIN_EN
            grant_o = (last_grant_i == OWNER_I) ? OWNER_D : OWNER_I;
`else
            grant_o = OWNER_D;
`endif
        end else if (d_valid_i) begin
            grant_o = OWNER_D;
        end else begin
            grant_o = OWNER_I;
        end
    end

endmodule : arbiter_grant_select

// File: rtl/unified_memory_arbiter.sv
// ----------------------------------------------------------------------------
// unified_memory_arbiter
//
// Purpose : Shares one memory port between an instruction-fetch requester and
//           a data (load/store) requester. Exactly one transaction is in
//           flight at a time: IDLE accepts a request, ISSUE presents it to
//           memory until mem_req_ready, WAIT collects the read data. Stores
//           finish at the ISSUE handshake with no response pulse.
//
// Build   : ARBITER_ROUND_ROBIN_EN selects round-robin tie-breaking; without it
//           the data port wins every tie.
//
// Params  : CORE         - core index, informational only
//           ADDRESS_BITS - address width of all request ports
//           DATA_WIDTH   - data width of all data ports
//
// Ports   : clock, reset (synchronous, active high)
//           i_req_valid/i_req_ready/i_req_address          - fetch request
//           d_req_valid/d_req_ready/d_req_write/
//           d_req_address/d_req_data                       - data request
//           i_resp_valid/d_resp_valid/resp_data            - read responses
//           mem_req_valid/mem_req_ready/mem_req_write/
//           mem_req_address/mem_req_data                   - memory request
//           mem_resp_valid/mem_resp_data                   - memory response
// ----------------------------------------------------------------------------
module unified_memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int CORE         = 0,
    parameter int ADDRESS_BITS = 20,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic                    i_req_valid,
    output logic                    i_req_ready,
    input  logic [ADDRESS_BITS-1:0] i_req_address,

    input  logic                    d_req_valid,
    output logic                    d_req_ready,
    input  logic                    d_req_write,
    input  logic [ADDRESS_BITS-1:0] d_req_address,
    input  logic [DATA_WIDTH-1:0]   d_req_data,

    output logic                    i_resp_valid,
    output logic                    d_resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_data,

    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_req_write,
    output logic [ADDRESS_BITS-1:0] mem_req_address,
    output logic [DATA_WIDTH-1:0]   mem_req_data,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_resp_data
);

    // The core index does not affect behaviour
    localparam int unusedCoreIndex = CORE;

    state_t                  state_q;
    owner_t                  owner_q;
    logic                    write_q;
    logic [ADDRESS_BITS-1:0] addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    memValid_q;
    logic [DATA_WIDTH-1:0]   respData_q;
    logic                    iResp_q;
    logic                    dResp_q;

    owner_t                  grant;
    owner_t                  lastGrant;
    logic                    acceptAny;

`ifdef ARBITER_ROUND_ROBIN_EN
    owner_t                  lastGrant_q;
    owner_t                  lastGrant_d;
`endif

    // Tie-break history only exists in round-robin builds; otherwise the
    // selector gets a constant it ignores
`ifdef ARBITER_ROUND_ROBIN_EN
    assign lastGrant = lastGrant_q;
`else
    assign lastGrant = OWNER_I;
`endif

    arbiter_grant_select u_grant_select (
        .i_valid_i    (i_req_valid),
        .d_valid_i    (d_req_valid),
        .last_grant_i (lastGrant),
        .grant_o      (grant)
    );

    // A request is taken only while idle and out of reset; ready goes only to
    // the granted requester and only when its valid is high
    assign acceptAny   = !reset && (state_q == ST_IDLE) && (i_req_valid || d_req_valid);
    assign i_req_ready = acceptAny && i_req_valid && (grant == OWNER_I);
    assign d_req_ready = acceptAny && d_req_valid && (grant == OWNER_D);

`ifdef ARBITER_ROUND_ROBIN_EN
    // Every acceptance records its winner for the next tie
    always_comb begin
        lastGrant_d = lastGrant_q;
        if (acceptAny) begin
            lastGrant_d = grant;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lastGrant_q <= OWNER_I;
        end else begin
            lastGrant_q <= lastGrant_d;
        end
    end
`endif

    // Transaction FSM. Latches the accepted request, holds it on the memory
    // port through ISSUE, and turns a WAIT-phase mem_resp_valid into a single
    // registered response pulse for the owner. Memory handshakes arriving in
    // any other phase fall through the case and are ignored.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWNER_I;
            write_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            memValid_q <= 1'b0;
            respData_q <= '0;
            iResp_q    <= 1'b0;
            dResp_q    <= 1'b0;
        end else begin
            iResp_q <= 1'b0;
            dResp_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (acceptAny) begin
                        state_q    <= ST_ISSUE;
                        memValid_q <= 1'b1;
                        owner_q    <= grant;
                        if (grant == OWNER_D) begin
                            write_q <= d_req_write;
                            addr_q  <= d_req_address;
                            data_q  <= d_req_data;
                        end else begin
                            // Fetches are always reads
                            write_q <= 1'b0;
                            addr_q  <= i_req_address;
                            data_q  <= '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (mem_req_ready) begin
                        memValid_q <= 1'b0;
                        state_q    <= write_q ? ST_IDLE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        respData_q <= mem_resp_data;
                        iResp_q    <= (owner_q == OWNER_I);
                        dResp_q    <= (owner_q == OWNER_D);
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    memValid_q <= 1'b0;
                end
            endcase
        end
    end

    // Memory request is held quiet while reset is asserted
    assign mem_req_valid   = memValid_q && !reset;
    assign mem_req_write   = write_q;
    assign mem_req_address = addr_q;
    assign mem_req_data    = data_q;

    assign i_resp_valid    = iResp_q;
    assign d_resp_valid    = dResp_q;
    assign resp_data       = respData_q;

endmodule : unified_memory_arbiter

// File: tb/tb_unified_memory_arbiter.sv
// ----------------------------------------------------------------------------
// tb_unified_memory_arbiter
//
// Self-checking bench for unified_memory_arbiter. Directed scenarios cover
// reset, a fetch read, a stalled store, tie-breaking, reset mid-read and a
// spurious memory response; a randomized run compares the DUT against a
// transaction-level reference model with a word-addressed memory image.
// Build with ARBITER_ROUND_ROBIN_EN to expect round-robin tie-breaking.
// ----------------------------------------------------------------------------
module tb_unified_memory_arbiter;

    localparam int  AW     = 20;
    localparam int  DW     = 32;
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    logic          clock;
    logic          reset;
    logic          i_req_valid;
    logic          i_req_ready;
    logic [AW-1:0] i_req_address;
    logic          d_req_valid;
    logic          d_req_ready;
    logic          d_req_write;
    logic [AW-1:0] d_req_address;
    logic [DW-1:0] d_req_data;
    logic          i_resp_valid;
    logic          d_resp_valid;
    logic [DW-1:0] resp_data;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic          mem_req_write;
    logic [AW-1:0] mem_req_address;
    logic [DW-1:0] mem_req_data;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;

    int compareCount;
    int mismatchCount;

    logic [DW-1:0] memModel [logic [AW-1:0]];

    unified_memory_arbiter #(
        .CORE         (0),
        .ADDRESS_BITS (AW),
        .DATA_WIDTH   (DW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .i_req_valid     (i_req_valid),
        .i_req_ready     (i_req_ready),
        .i_req_address   (i_req_address),
        .d_req_valid     (d_req_valid),
        .d_req_ready     (d_req_ready),
        .d_req_write     (d_req_write),
        .d_req_address   (d_req_address),
        .d_req_data      (d_req_data),
        .i_resp_valid    (i_resp_valid),
        .d_resp_valid    (d_resp_valid),
        .resp_data       (resp_data),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_write   (mem_req_write),
        .mem_req_address (mem_req_address),
        .mem_req_data    (mem_req_data),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_data   (mem_resp_data)
    );

    // Free-running clock, 10 time units per cycle
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory image lookup; unwritten words read back an address-derived pattern
    function automatic logic [DW-1:0] memRead(input logic [AW-1:0] addr);
        if (memModel.exists(addr)) return memModel[addr];
        return {12'hC0D, addr};
    endfunction

    // Advance to just after the next rising edge, where inputs are driven
    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idleInputs();
        i_req_valid    = 1'b0;
        i_req_address  = '0;
        d_req_valid    = 1'b0;
        d_req_write    = 1'b0;
        d_req_address  = '0;
        d_req_data     = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
    endtask

    task automatic doReset();
        nextCycle();
        idleInputs();
        reset = 1'b1;
        nextCycle();
        nextCycle();
        reset = 1'b0;
    endtask

    // Outputs while reset is held, with both requesters pushing
    task automatic test_reset();
        nextCycle();
        reset       = 1'b1;
        i_req_valid = 1'b1;
        d_req_valid = 1'b1;
        nextCycle();
        @(negedge clock);
        compareCount++; if (i_req_ready !== 1'b0) begin mismatchCount++; $display("[TB] FAIL reset_i_ready got %b want 0", i_req_ready); end
        compareCount++; if (d_req_ready !== 1'b0) begin mismatchCount++; $display("[TB] FAIL reset_d_ready got %b want 0", d_req_ready); end
        compareCount++; if (mem_req_valid !== 1'b0) begin mismatchCount++; $display("[TB] FAIL reset_mem_valid got %b want 0", mem_req_valid); end
        compareCount++; if ({i_resp_valid, d_resp_valid} !== 2'b00) begin mismatchCount++; $display("[TB] FAIL reset_resp_valid got %b%b want 00", i_resp_valid, d_resp_valid); end
        compareCount++; if (resp_data !== '0) begin mismatchCount++; $display("[TB] FAIL reset_resp_data got %h want 0", resp_data); end
        compareCount++; if ({mem_req_write, mem_req_address, mem_req_data} !== '0) begin mismatchCount++; $display("[TB] FAIL reset_mem_fields got w=%b a=%h d=%h want all 0", mem_req_write, mem_req_address, mem_req_data); end
        nextCycle();
        idleInputs();
        reset = 1'b0;
    endtask

    // Instruction fetch at 0x00010 answered with 0xDEADBEEF
    task automatic test_fetch();
        i_req_valid   = 1'b1;
        i_req_address = 20'h00010;
        @(negedge clock);
        compareCount++; if ({i_req_ready, d_req_ready} !== 2'b10) begin mismatchCount++; $display("[TB] FAIL fetch_accept got i=%b d=%b want i=1 d=0", i_req_ready, d_req_ready); end
        nextCycle();
        i_req_valid   = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clock);
        compareCount++; if ({mem_req_valid, mem_req_write, mem_req_address} !== {2'b10, 20'h00010}) begin mismatchCount++; $display("[TB] FAIL fetch_issue got v=%b w=%b a=%h want v=1 w=0 a=00010", mem_req_valid, mem_req_write, mem_req_address); end
        nextCycle();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hDEADBEEF;
        @(negedge clock);
        compareCount++; if ({mem_req_valid, i_resp_valid, d_resp_valid} !== 3'b000) begin mismatchCount++; $display("[TB] FAIL fetch_wait got v=%b ir=%b dr=%b want 000", mem_req_valid, i_resp_valid, d_resp_valid); end
        nextCycle();
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        @(negedge clock);
        compareCount++; if ({i_resp_valid, d_resp_valid} !== 2'b10) begin mismatchCount++; $display("[TB] FAIL fetch_resp_pulse got i=%b d=%b want i=1 d=0", i_resp_valid, d_resp_valid); end
        compareCount++; if (resp_data !== 32'hDEADBEEF) begin mismatchCount++; $display("[TB] FAIL fetch_resp_data got %h want deadbeef", resp_data); end
        nextCycle();
        @(negedge clock);
        compareCount++; if ({i_resp_valid, d_resp_valid} !== 2'b00) begin mismatchCount++; $display("[TB] FAIL fetch_pulse_width got i=%b d=%b want 00", i_resp_valid, d_resp_valid); end
        nextCycle();
    endtask

    // Memory response with nothing outstanding must be ignored
    task automatic test_spurious_resp();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0BADF00D;
        @(negedge clock);
        compareCount++; if ({i_resp_valid, d_resp_valid} !== 2'b00) begin mismatchCount++; $display("[TB] FAIL spurious_same_cycle got i=%b d=%b want 00", i_resp_valid, d_resp_valid); end
        nextCycle();
        mem_resp_valid = 1'b0;
        @(negedge clock);
        compareCount++; if ({i_resp_valid, d_resp_valid} !== 2'b00) begin mismatchCount++; $display("[TB] FAIL spurious_pulse got i=%b d=%b want 00", i_resp_valid, d_resp_valid); end
        compareCount++; if (resp_data !== 32'hDEADBEEF) begin mismatchCount++; $display("[TB] FAIL spurious_resp_data got %h want deadbeef", resp_data); end
        nextCycle();
    endtask

    // Store held off by memory for three cycles
    task automatic test_store_stall();
        d_req_valid   = 1'b1;
        d_req_write   = 1'b1;
        d_req_address = 20'h00100;
        d_req_data    = 32'h12345678;
        @(negedge clock);
        compareCount++; if ({i_req_ready, d_req_ready} !== 2'b01) begin mismatchCount++; $display("[TB] FAIL store_accept got i=%b d=%b want i=0 d=1", i_req_ready, d_req_ready); end
        for (int k = 0; k < 4; k++) begin
            nextCycle();
            d_req_valid   = 1'b0;
            mem_req_ready = (k == 3);
            @(negedge clock);
            compareCount++; if ({mem_req_valid, mem_req_write, mem_req_address, mem_req_data} !== {2'b11, 20'h00100, 32'h12345678}) begin mismatchCount++; $display("[TB] FAIL store_hold_%0d got v=%b w=%b a=%h d=%h want v=1 w=1 a=00100 d=12345678", k, mem_req_valid, mem_req_write, mem_req_address, mem_req_data); end
        end
        nextCycle();
        mem_req_ready = 1'b0;
        @(negedge clock);
        compareCount++; if ({mem_req_valid, i_resp_valid, d_resp_valid} !== 3'b000) begin mismatchCount++; $display("[TB] FAIL store_done got v=%b ir=%b dr=%b want 000", mem_req_valid, i_resp_valid, d_resp_valid); end
        nextCycle();
        i_req_valid   = 1'b1;
        i_req_address = 20'h00020;
        @(negedge clock);
        compareCount++; if ({i_req_ready, i_resp_valid, d_resp_valid} !== 3'b100) begin mismatchCount++; $display("[TB] FAIL store_back_idle got ready=%b ir=%b dr=%b want 100", i_req_ready, i_resp_valid, d_resp_valid); end
        doReset();
    endtask

    // Both requesters valid for four transactions in a row
    task automatic test_back_to_back();
        logic expOwner;
        logic gotOwner;
`ifdef ARBITER_ROUND_ROBIN_EN
        logic tieLast;
        tieLast = OWN_I;
`endif
        doReset();
        for (int k = 0; k < 4; k++) begin
            i_req_valid    = 1'b1;
            i_req_address  = 20'h00200 + 20'(k);
            d_req_valid    = 1'b1;
            d_req_write    = 1'b1;
            d_req_address  = 20'h00300 + 20'(k);
            d_req_data     = $urandom;
            mem_req_ready  = 1'b1;
            mem_resp_valid = 1'b0;
            @(negedge clock);
`ifdef ARBITER_ROUND_ROBIN_EN
            expOwner = (tieLast == OWN_I) ? OWN_D : OWN_I;
            tieLast  = expOwner;
`else
            expOwner = OWN_D;
`endif
            gotOwner = d_req_ready ? OWN_D : OWN_I;
            compareCount++; if ((i_req_ready ^ d_req_ready) !== 1'b1 || gotOwner !== expOwner) begin mismatchCount++; $display("[TB] FAIL tie_grant_%0d got i=%b d=%b want owner %b", k, i_req_ready, d_req_ready, expOwner); end
            nextCycle();
            @(negedge clock);
            compareCount++; if ({mem_req_valid, mem_req_write} !== {1'b1, expOwner}) begin mismatchCount++; $display("[TB] FAIL tie_issue_%0d got v=%b w=%b want v=1 w=%b", k, mem_req_valid, mem_req_write, expOwner); end
            nextCycle();
            if (expOwner == OWN_I) begin
                mem_req_ready  = 1'b0;
                mem_resp_valid = 1'b1;
                mem_resp_data  = $urandom;
                nextCycle();
            end
        end
        doReset();
    endtask

    // Reset lands while a load waits for data; the late data is dropped
    task automatic test_reset_in_wait();
        d_req_valid   = 1'b1;
        d_req_write   = 1'b0;
        d_req_address = 20'h00040;
        @(negedge clock);
        compareCount++; if (d_req_ready !== 1'b1) begin mismatchCount++; $display("[TB] FAIL rwait_accept got %b want 1", d_req_ready); end
        nextCycle();
        d_req_valid   = 1'b0;
        mem_req_ready = 1'b1;
        nextCycle();
        mem_req_ready = 1'b0;
        reset         = 1'b1;
        @(negedge clock);
        compareCount++; if ({mem_req_valid, d_req_ready, i_req_ready} !== 3'b000) begin mismatchCount++; $display("[TB] FAIL rwait_during_reset got v=%b dr=%b ir=%b want 000", mem_req_valid, d_req_ready, i_req_ready); end
        nextCycle();
        reset          = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hCAFEF00D;
        @(negedge clock);
        compareCount++; if ({i_resp_valid, d_resp_valid} !== 2'b00) begin mismatchCount++; $display("[TB] FAIL rwait_late_same got i=%b d=%b want 00", i_resp_valid, d_resp_valid); end
        nextCycle();
        mem_resp_valid = 1'b0;
        d_req_valid    = 1'b1;
        @(negedge clock);
        compareCount++; if ({i_resp_valid, d_resp_valid} !== 2'b00) begin mismatchCount++; $display("[TB] FAIL rwait_no_pulse got i=%b d=%b want 00", i_resp_valid, d_resp_valid); end
        compareCount++; if ({d_req_ready, resp_data} !== {1'b1, 32'h0}) begin mismatchCount++; $display("[TB] FAIL rwait_idle got ready=%b data=%h want ready=1 data=0", d_req_ready, resp_data); end
        doReset();
    endtask

    // Random traffic against a transaction-level model of the arbiter
    task automatic test_random_traffic();
        int            phase;
        logic          curOwner;
        logic          curWrite;
        logic [AW-1:0] curAddr;
        logic [DW-1:0] curData;
        logic          respPending;
        logic          respOwner;
        logic [DW-1:0] respExp;
        logic [DW-1:0] lastResp;
        logic          nextPending;
        logic          gOwner;
        logic          expI;
        logic          expD;
`ifdef ARBITER_ROUND_ROBIN_EN
        logic          mLast;
        mLast = OWN_I;
`endif
        doReset();
        memModel.delete();
        phase       = 0;
        curOwner    = OWN_I;
        curWrite    = 1'b0;
        curAddr     = '0;
        curData     = '0;
        respPending = 1'b0;
        respOwner   = OWN_I;
        respExp     = '0;
        lastResp    = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            i_req_valid   = ($urandom_range(0, 2) != 0);
            i_req_address = AW'($urandom_range(0, 7) * 4);
            d_req_valid   = ($urandom_range(0, 2) != 0);
            d_req_write   = ($urandom_range(0, 1) != 0);
            d_req_address = AW'($urandom_range(0, 7) * 4);
            d_req_data    = $urandom;
            mem_req_ready = ($urandom_range(0, 1) != 0);
            if (phase == 2) begin
                mem_resp_valid = ($urandom_range(0, 2) == 0);
                mem_resp_data  = memRead(curAddr);
            end else begin
                mem_resp_valid = ($urandom_range(0, 5) == 0);
                mem_resp_data  = $urandom;
            end
            @(negedge clock);
            if (respPending) lastResp = respExp;
            compareCount++; if (i_resp_valid !== (respPending && respOwner == OWN_I)) begin mismatchCount++; $display("[TB] FAIL rnd_i_resp cycle %0d got %b want %b", cyc, i_resp_valid, respPending && respOwner == OWN_I); end
            compareCount++; if (d_resp_valid !== (respPending && respOwner == OWN_D)) begin mismatchCount++; $display("[TB] FAIL rnd_d_resp cycle %0d got %b want %b", cyc, d_resp_valid, respPending && respOwner == OWN_D); end
            compareCount++; if (resp_data !== lastResp) begin mismatchCount++; $display("[TB] FAIL rnd_resp_data cycle %0d got %h want %h", cyc, resp_data, lastResp); end
            nextPending = 1'b0;
            case (phase)
                0: begin
                    if (i_req_valid && d_req_valid) begin
`ifdef ARBITER_ROUND_ROBIN_EN
                        gOwner = (mLast == OWN_I) ? OWN_D : OWN_I;
`else
                        gOwner = OWN_D;
`endif
                    end else begin
                        gOwner = d_req_valid ? OWN_D : OWN_I;
                    end
                    expI = i_req_valid && (gOwner == OWN_I);
                    expD = d_req_valid && (gOwner == OWN_D);
                    compareCount++; if ({i_req_ready, d_req_ready} !== {expI, expD}) begin mismatchCount++; $display("[TB] FAIL rnd_grant cycle %0d got i=%b d=%b want i=%b d=%b", cyc, i_req_ready, d_req_ready, expI, expD); end
                    compareCount++; if (mem_req_valid !== 1'b0) begin mismatchCount++; $display("[TB] FAIL rnd_idle_mem_valid cycle %0d got %b want 0", cyc, mem_req_valid); end
                    if (i_req_valid || d_req_valid) begin
                        curOwner = gOwner;
                        if (gOwner == OWN_D) begin
                            curWrite = d_req_write;
                            curAddr  = d_req_address;
                            curData  = d_req_data;
                        end else begin
                            curWrite = 1'b0;
                            curAddr  = i_req_address;
                        end
`ifdef ARBITER_ROUND_ROBIN_EN
                        mLast = gOwner;
`endif
                        phase = 1;
                    end
                end
                1: begin
                    compareCount++; if ({i_req_ready, d_req_ready, mem_req_valid} !== 3'b001) begin mismatchCount++; $display("[TB] FAIL rnd_issue_hs cycle %0d got ir=%b dr=%b v=%b want 001", cyc, i_req_ready, d_req_ready, mem_req_valid); end
                    compareCount++; if ({mem_req_write, mem_req_address} !== {curWrite, curAddr}) begin mismatchCount++; $display("[TB] FAIL rnd_issue_req cycle %0d got w=%b a=%h want w=%b a=%h", cyc, mem_req_write, mem_req_address, curWrite, curAddr); end
                    if (curWrite) begin
                        compareCount++; if (mem_req_data !== curData) begin mismatchCount++; $display("[TB] FAIL rnd_issue_data cycle %0d got %h want %h", cyc, mem_req_data, curData); end
                    end
                    if (mem_req_ready) begin
                        if (curWrite) begin
                            memModel[curAddr] = curData;
                            phase = 0;
                        end else begin
                            phase = 2;
                        end
                    end
                end
                default: begin
                    compareCount++; if ({i_req_ready, d_req_ready, mem_req_valid} !== 3'b000) begin mismatchCount++; $display("[TB] FAIL rnd_wait cycle %0d got ir=%b dr=%b v=%b want 000", cyc, i_req_ready, d_req_ready, mem_req_valid); end
                    if (mem_resp_valid) begin
                        nextPending = 1'b1;
                        respOwner   = curOwner;
                        respExp     = memRead(curAddr);
                        phase       = 0;
                    end
                end
            endcase
            respPending = nextPending;
            nextCycle();
        end
        idleInputs();
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        reset         = 1'b1;
        idleInputs();
        test_reset();
        test_fetch();
        test_spurious_resp();
        test_store_stall();
        test_back_to_back();
        test_reset_in_wait();
        test_random_traffic();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule : tb_unified_memory_arbiter
